umi_mux_arbiter: RTL and testbench
==================================

UMI_MUX_ARBITER -- requirements
Module: umi_mux_arbiter

Interface
REQ-001 Parameter N, default 4: number of UMI input ports, legal range 2..16.
REQ-002 Parameter UW, default 256: UMI packet width in bits.
REQ-003 Parameter TARGET, default "DEFAULT": implementation target string, passed through only.
REQ-004 umi_clk  input  1: single clock; all state is sampled on its rising edge.
REQ-005 umi_reset  input  1: reset, synchronous and active-high.
REQ-006 arbmode  input  1: arbitration mode; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 arbmask  input  N: per-input disable; bit i = 1 excludes input i from arbitration.
REQ-008 umi_in_valid  input  N: per-input valid.
REQ-009 umi_in_packet  input  N*UW: input packets, with input i at bits [i*UW +: UW].
REQ-010 umi_in_ready  output  N: per-input ready.
REQ-011 umi_out_valid  output  1: output valid (registered).
REQ-012 umi_out_packet  output  UW: output packet (registered).
REQ-013 umi_out_ready  input  1: output ready.
REQ-014 umi_out_src  output  clog2(N): index of the input that sourced the current output packet (registered).

Function
REQ-015 Eligible request: req[i] = umi_in_valid[i] & ~arbmask[i].
REQ-016 Output slot free: slot_free = ~umi_out_valid | umi_out_ready.
REQ-017 Grant: exactly one-hot or zero; combinational from req, arbmode and the priority pointer.
REQ-018 umi_in_ready[i] = slot_free & grant[i].
- No combinational path from umi_in_valid[i] to umi_in_ready[j] when grant is zero.
REQ-019 Transfer on input i occurs when umi_in_valid[i] & umi_in_ready[i]; at most one transfer per cycle.
REQ-020 On a transfer, on the next edge:
- umi_out_packet <= packet i
- umi_out_src <= i
- umi_out_valid <= 1
- Latency from input handshake to umi_out_valid is exactly 1 cycle.
REQ-021 If slot_free and no transfer, umi_out_valid <= 0 on the next edge; packet and src hold.
REQ-022 While umi_out_valid=1 and umi_out_ready=0, umi_out_valid, umi_out_packet and umi_out_src hold, and all umi_in_ready are 0.
REQ-023 Back-to-back: with umi_out_ready held at 1 and continuous requests, the block sustains one packet per cycle.
REQ-024 Round-robin mode: the priority pointer ptr (clog2(N) bits) names the highest-priority input; search order is ptr, ptr+1, ..., wrapping modulo N.
REQ-025 Round-robin mode: on a transfer from input i, ptr <= (i+1) mod N, with wrap from N-1 to 0; ptr holds otherwise.
REQ-026 Fixed mode: the lowest-index eligible request wins; ptr holds.
REQ-027 Changing arbmode or arbmask takes effect on the next grant computation.
- A packet already in the output register is unaffected.
REQ-028 No starvation in round-robin mode: each continuously eligible input is granted within N transfers.
REQ-029 Input packets are not modified; the block performs no UMI field decode.

Reset
REQ-030 While umi_reset=1, on each edge: umi_out_valid <= 0, ptr <= 0, umi_out_src <= 0.
REQ-031 While umi_reset=1, umi_in_ready is all zero combinationally, so no transfer occurs.
REQ-032 umi_out_packet has no reset; its value is don't-care while umi_out_valid=0.
REQ-033 Reset asserted mid-stream discards any held output packet; the first grant after release goes to the lowest-index eligible input.

Structure
REQ-034 Shared package umi_pkg holds:
- the clog2 helper function
- the arbmode encoding constants ARB_RR=0 and ARB_FIXED=1
REQ-035 Grant logic lives in one sub-module, umi_arbiter_rr.
- Inputs: req, ptr, mode.
- Output: grant, one-hot.
- Purely combinational.
REQ-036 The output register, ptr register and packet mux reside in umi_mux_arbiter.

Verification
REQ-037 Test: N=4, all valid=1, out_ready=1, arbmode=0. Required: grants cycle 0,1,2,3,0; umi_out_src follows one cycle later; one packet per cycle.
REQ-038 Test: arbmode=1, valid=4'b1010. Required: input 1 is granted every cycle and input 3 never, until valid[1] falls.
REQ-039 Test: out_ready=0 for 5 cycles while out_valid=1 with packet 0xA5. Required: packet, src and valid hold; umi_in_ready=0; one transfer resumes on the cycle out_ready=1.
REQ-040 Test: arbmask=4'b0001, all valid. Required: input 0 never receives ready; grants rotate 1,2,3.
REQ-041 Test: assert umi_reset for 1 cycle while out_valid=1. Required: out_valid=0 next cycle; ptr=0; the next grant goes to input 0 when it is valid.
REQ-042 Test: ptr=3, only input 3 valid, then all valid. Required: input 3 transfers, ptr wraps to 0, and the next grant goes to input 0.

Source files
------------

// File: rtl/umi_pkg.sv
// Shared UMI definitions: arbitration mode encodings
// and the width helper used by the mux/arbiter slice.
package umi_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/umi_arbiter_rr.sv
// Combinational grant: round-robin from ptr, or
// fixed priority from index 0. Grant is one-hot or zero.
module umi_arbiter_rr
  import umi_pkg::*;
#(
  parameter int N  = 4,
  localparam int AW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant
);

  int   base;
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    base  = (mode == ARB_FIXED) ? 0 : int'(ptr);
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_mux_arbiter.sv
// N-to-1 UMI mux with a registered output slot,
// round-robin or fixed-priority arbitration.
module umi_mux_arbiter
  import umi_pkg::*;
#(
  parameter int N      = 4,
  parameter int UW     = 256,
  parameter     TARGET = "DEFAULT",
  localparam int AW    = clog2(N)
) (
  input  logic          umi_clk,
  input  logic          umi_reset,
  input  logic          arbmode,
  input  logic [N-1:0]  arbmask,
  input  logic [N-1:0]  umi_in_valid,
  input  logic [N*UW-1:0] umi_in_packet,
  output logic [N-1:0]  umi_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready,
  output logic [AW-1:0] umi_out_src
);

  logic          valid_q;
  logic [UW-1:0] pkt_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          slot_free;
  logic          xfer;
  logic [AW-1:0] gidx;
  logic [UW-1:0] sel;

  assign req       = umi_in_valid & ~arbmask;
  assign slot_free = ~valid_q | umi_out_ready;

  umi_arbiter_rr #(.N(N)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .mode  (arbmode),
    .grant (grant)
  );

  // Grant only asserts on eligible inputs, so any ready is a transfer.
  assign umi_in_ready = grant & {N{slot_free & ~umi_reset}};
  assign xfer         = |umi_in_ready;

  always_comb begin
    gidx = '0;
    sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx = gidx | AW'(i);
        sel  = sel | umi_in_packet[i*UW +: UW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && arbmode == ARB_RR)
      ptr_d = (gidx == AW'(N - 1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge umi_clk) begin
    if (umi_reset) begin
      valid_q <= 1'b0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        valid_q <= 1'b1;
        src_q   <= gidx;
      end else if (slot_free) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge umi_clk) begin
    if (xfer) pkt_q <= sel;
  end

  assign umi_out_valid  = valid_q;
  assign umi_out_packet = pkt_q;
  assign umi_out_src    = src_q;

endmodule

// File: tb/tb_umi_mux_arbiter.sv
// Directed vector bench for umi_mux_arbiter (N=4):
// ready checked before each edge, output slot after it.
module tb_umi_mux_arbiter;
  import umi_pkg::*;

  localparam int N  = 4;
  localparam int UW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [N-1:0]  mask;
  logic [N-1:0]  valid;
  logic [N*UW-1:0] pkts;
  logic [N-1:0]  rdy;
  logic          ov;
  logic [UW-1:0] opkt;
  logic          ordy;
  logic [1:0]    osrc;

  always #5 clk = ~clk;

  umi_mux_arbiter #(.N(N), .UW(UW), .TARGET("DEFAULT")) dut (
    .umi_clk        (clk),
    .umi_reset      (rst),
    .arbmode        (mode),
    .arbmask        (mask),
    .umi_in_valid   (valid),
    .umi_in_packet  (pkts),
    .umi_in_ready   (rdy),
    .umi_out_valid  (ov),
    .umi_out_packet (opkt),
    .umi_out_ready  (ordy),
    .umi_out_src    (osrc)
  );

  typedef struct {
    logic       rst;
    logic       mode;
    logic [3:0] mask;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_src;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [UW-1:0] pv [N];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic r, input logic m,
                     input logic [3:0] mk, input logic [3:0] v,
                     input logic o, input logic [3:0] er,
                     input logic eo, input logic [1:0] es,
                     input string nm);
    vec_t x;
    x.rst = r; x.mode = m; x.mask = mk; x.valid = v;
    x.ordy = o; x.exp_rdy = er; x.exp_ov = eo;
    x.exp_src = es; x.name = nm;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [UW-1:0] act,
                     input logic [UW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t x);
    rst = x.rst; mode = x.mode; mask = x.mask;
    valid = x.valid; ordy = x.ordy;
    #1;
    chk({x.name, ".ready"}, UW'(rdy), UW'(x.exp_rdy));
    @(posedge clk);
    #1;
    chk({x.name, ".ovalid"}, UW'(ov), UW'(x.exp_ov));
    chk({x.name, ".src"}, UW'(osrc), UW'(x.exp_src));
    if (x.exp_ov)
      chk({x.name, ".pkt"}, opkt, pv[x.exp_src]);
  endtask

  initial begin
    pv[0] = 32'h0000_00A5;
    pv[1] = 32'h1111_1111;
    pv[2] = 32'h2222_2222;
    pv[3] = 32'h3333_3333;
    for (int i = 0; i < N; i++) pkts[i*UW +: UW] = pv[i];

    // r  m  mask     valid    ordy rdy      ov src
    add(1, 0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, "rst0");
    add(1, 0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, "rst1");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, "rr0");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0010, 1, 1, "rr1");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0100, 1, 2, "rr2");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b1000, 1, 3, "rr3");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, "rr4");
    add(0, 1, 4'b0000, 4'b1010, 1, 4'b0010, 1, 1, "fx0");
    add(0, 1, 4'b0000, 4'b1010, 1, 4'b0010, 1, 1, "fx1");
    add(0, 1, 4'b0000, 4'b1010, 1, 4'b0010, 1, 1, "fx2");
    add(0, 1, 4'b0000, 4'b1000, 1, 4'b1000, 1, 3, "fx3");
    add(0, 0, 4'b0001, 4'b1111, 1, 4'b0010, 1, 1, "mk0");
    add(0, 0, 4'b0001, 4'b1111, 1, 4'b0100, 1, 2, "mk1");
    add(0, 0, 4'b0001, 4'b1111, 1, 4'b1000, 1, 3, "mk2");
    add(0, 0, 4'b0001, 4'b1111, 1, 4'b0010, 1, 1, "mk3");
    add(0, 1, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, "bp_load");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Backpressure: slot holds 0xA5 from input 0, ptr=2.
    tbl.delete();
    for (int i = 0; i < 5; i++)
      add(0, 0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 0, "stall");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0100, 1, 2, "resume");
    // ptr=3: lone input 3 wraps ptr to 0.
    add(0, 0, 4'b0000, 4'b1000, 1, 4'b1000, 1, 3, "wrap3");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0001, 1, 0, "wrap0");
    add(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, "idle");
    add(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "idle_nr");
    add(0, 0, 4'b0000, 4'b1111, 0, 4'b0010, 1, 1, "empty_nr");
    // Mid-stream reset with a held packet, then ptr restarts at 0.
    add(1, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, "mrst");
    add(0, 0, 4'b0000, 4'b1111, 0, 4'b0001, 1, 0, "post_rst");
    add(0, 0, 4'b0000, 4'b1111, 1, 4'b0010, 1, 1, "post_rst1");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
